// File: rtl/fnum_block_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : fnum_block_encoder
//  Brief    : Converts a target frequency word into an F-number / block pair
//             by shifting right until the word fits the F-number field,
//             tracking whether any set bits were shifted out.
//  Revision : 1.0 - initial release
// ============================================================================
module fnum_block_encoder #(
    parameter int REG_FNUM_WIDTH  = 10,
    parameter int REG_BLOCK_WIDTH = 3,
    parameter int IN_WIDTH        = REG_FNUM_WIDTH + 2**REG_BLOCK_WIDTH - 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_WIDTH-1:0]        in_word,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [REG_FNUM_WIDTH-1:0]  fnum,
    output logic [REG_BLOCK_WIDTH-1:0] block,
    output logic                       inexact
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Largest representable block; with the default IN_WIDTH the word always
    // fits before this is reached, so the counter can never wrap.
    localparam logic [REG_BLOCK_WIDTH-1:0] C_BLK_MAX = '1;

    state_t                      state_q,   state_d;
    logic [IN_WIDTH-1:0]         sr_q,      sr_d;
    logic [REG_BLOCK_WIDTH-1:0]  blk_q,     blk_d;
    logic                        sticky_q,  sticky_d;
    logic [REG_FNUM_WIDTH-1:0]   fnum_q,    fnum_d;
    logic [REG_BLOCK_WIDTH-1:0]  block_q,   block_d;
    logic                        inexact_q, inexact_d;

    logic                        w_fits;

    // Word fits the F-number field once every bit above it is clear.
    assign w_fits = (sr_q[IN_WIDTH-1:REG_FNUM_WIDTH] == '0);

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);

    assign fnum    = fnum_q;
    assign block   = block_q;
    assign inexact = inexact_q;

    // Next-state and datapath update: load in IDLE, shift in NORM, hold in DONE.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        blk_d     = blk_q;
        sticky_d  = sticky_q;
        fnum_d    = fnum_q;
        block_d   = block_q;
        inexact_d = inexact_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sr_d     = in_word;
                    blk_d    = '0;
                    sticky_d = 1'b0;
                    state_d  = S_NORM;
                end
            end
            S_NORM: begin
                if (w_fits || (blk_q == C_BLK_MAX)) begin
                    fnum_d    = sr_q[REG_FNUM_WIDTH-1:0];
                    block_d   = blk_q;
                    inexact_d = sticky_q;
                    state_d   = S_DONE;
                end else begin
                    sr_d     = sr_q >> 1;
                    sticky_d = sticky_q | sr_q[0];
                    blk_d    = blk_q + 1'b1;
                end
            end
            S_DONE: begin
                // Result stays frozen until the consumer takes it; no new
                // word can be accepted on this same edge.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            blk_q     <= '0;
            sticky_q  <= 1'b0;
            fnum_q    <= '0;
            block_q   <= '0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            blk_q     <= blk_d;
            sticky_q  <= sticky_d;
            fnum_q    <= fnum_d;
            block_q   <= block_d;
            inexact_q <= inexact_d;
        end
    end

endmodule
`default_nettype wire
